ram_sync: RTL

RAM_SYNC -- requirements
Module: ram_sync

---
 rtl/ram_sync_if.sv | 32 +++
 rtl/ram_sync.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ram_sync_if.sv
// Bus bundle for ram_sync: port A (read/write, byte enables) and port B (read-only).
// The master modport drives requests; the slave modport is the memory side.
interface ram_sync_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  a_cs;
  logic                  a_we;
  logic [NB-1:0]         a_be;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_rvalid;
  logic                  b_cs;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_rvalid;
  logic                  busy;

  modport master (
    output a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_addr,
    input  a_rdata, a_rvalid, b_rdata, b_rvalid, busy
  );

  modport slave (
    input  a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_addr,
    output a_rdata, a_rvalid, b_rdata, b_rvalid, busy
  );
endinterface

// File: rtl/ram_sync.sv
// Dual-port synchronous RAM: port A read/write with byte enables, port B read-only.
// After reset the array is zero-filled one word per cycle while busy is high.
module ram_sync #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input logic       clk,
  input logic       rst,
  ram_sync_if.slave bus
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CLR_ONE  = (ADDR_WIDTH + 1)'(1);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("ram_sync: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bytes
      $error("ram_sync: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state_reg, state_next;
  logic [ADDR_WIDTH:0]   clr_cnt_reg, clr_cnt_next;
  logic                  idle;
  logic                  a_wr, a_rd, b_rd;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] a_mem_word, b_mem_word, b_fwd_word, b_sel_word;
  logic [DATA_WIDTH-1:0] a_q_reg, b_q_reg;
  logic                  a_v_reg, b_v_reg;

  // Clear sequencer: one word per cycle, leave INIT after the last address.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    if (state_reg == ST_INIT) begin
      clr_cnt_next = clr_cnt_reg + CLR_ONE;
      if (clr_cnt_reg == CLR_LAST) begin
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_INIT;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  assign idle     = (state_reg == ST_IDLE);
  assign bus.busy = ~idle;
  assign a_wr     = idle & bus.a_cs & bus.a_we;
  assign a_rd     = idle & bus.a_cs & ~bus.a_we;
  assign b_rd     = idle & bus.b_cs;

  // The clear sequence borrows port A's write path.
  assign wr_en   = ~idle | a_wr;
  assign wr_addr = idle ? bus.a_addr  : clr_cnt_reg[ADDR_WIDTH-1:0];
  assign wr_be   = idle ? bus.a_be    : '1;
  assign wr_data = idle ? bus.a_wdata : '0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_en && wr_be[i]) begin
        mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign a_mem_word = mem[bus.a_addr];
  assign b_mem_word = mem[bus.b_addr];

  // Write-first view for port B: enabled bytes of a same-address write bypass the array.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_merge
      assign b_fwd_word[gi*BYTE_WIDTH +: BYTE_WIDTH] =
          (a_wr && bus.a_be[gi] && (bus.a_addr == bus.b_addr))
          ? bus.a_wdata[gi*BYTE_WIDTH +: BYTE_WIDTH]
          : b_mem_word[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  assign b_sel_word = (WRITE_MODE == 1) ? b_fwd_word : b_mem_word;

  // Read registers only load on an accepted read, so data holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q_reg <= '0;
      b_q_reg <= '0;
      a_v_reg <= 1'b0;
      b_v_reg <= 1'b0;
    end else begin
      a_v_reg <= a_rd;
      b_v_reg <= b_rd;
      if (a_rd) begin
        a_q_reg <= a_mem_word;
      end
      if (b_rd) begin
        b_q_reg <= b_sel_word;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] a_o_reg, b_o_reg;
      logic                  a_ov_reg, b_ov_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_o_reg  <= '0;
          b_o_reg  <= '0;
          a_ov_reg <= 1'b0;
          b_ov_reg <= 1'b0;
        end else begin
          a_ov_reg <= a_v_reg;
          b_ov_reg <= b_v_reg;
          if (a_v_reg) begin
            a_o_reg <= a_q_reg;
          end
          if (b_v_reg) begin
            b_o_reg <= b_q_reg;
          end
        end
      end

      assign bus.a_rdata  = a_o_reg;
      assign bus.a_rvalid = a_ov_reg;
      assign bus.b_rdata  = b_o_reg;
      assign bus.b_rvalid = b_ov_reg;
    end else begin : g_lat1
      assign bus.a_rdata  = a_q_reg;
      assign bus.a_rvalid = a_v_reg;
      assign bus.b_rdata  = b_q_reg;
      assign bus.b_rvalid = b_v_reg;
    end
  endgenerate

endmodule
